// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants shared by the seven-segment scan multiplexer
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Segment order {a,b,c,d,e,f,g}; a 0 bit lights the segment
  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b1100000;
  localparam seg_t SEG_C     = 7'b0110001;
  localparam seg_t SEG_D     = 7'b1000010;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_F     = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational 4-bit code to active-low segment pattern
module seg7_glyph
  import seg7_pkg::*;
#(
  parameter int HEX_EN = 0
) (
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  localparam bit HEX_ON = (HEX_EN != 0);

  // Codes above 9 are only drawn when hex glyphs are enabled
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = HEX_ON ? SEG_A : SEG_BLANK;
      4'hB: pattern = HEX_ON ? SEG_B : SEG_BLANK;
      4'hC: pattern = HEX_ON ? SEG_C : SEG_BLANK;
      4'hD: pattern = HEX_ON ? SEG_D : SEG_BLANK;
      4'hE: pattern = HEX_ON ? SEG_E : SEG_BLANK;
      4'hF: pattern = HEX_ON ? SEG_F : SEG_BLANK;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed seven-segment driver with frame-aligned updates
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int CLK_DIV  = 50000,
  parameter int GUARD    = 2,
  parameter int HEX_EN   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic                  lzb_en,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  upd_pend,
  output logic                  frame_tick
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PRE_W-1:0] presc;
  logic [IDX_W-1:0] idx;
  logic             slot_tick;
  logic             boundary;

  logic [4*N_DIGITS-1:0] pend_digits;
  logic [N_DIGITS-1:0]   pend_dp;
  logic [N_DIGITS-1:0]   pend_blank;
  logic [4*N_DIGITS-1:0] disp_digits;
  logic [N_DIGITS-1:0]   disp_dp;
  logic [N_DIGITS-1:0]   disp_blank;

  logic [N_DIGITS-1:0]   lz_mask;
  logic                  lz_run;
  logic [3:0]            cur_code;
  logic [6:0]            glyph_seg;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [N_DIGITS-1:0]   an_nxt;

  assign slot_tick = (presc == PRE_LAST);
  assign boundary  = slot_tick && (idx == IDX_LAST);

  // Prescaler wraps every CLK_DIV cycles and steps the scanned digit
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_tick) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // One-cycle pulse after the last digit's slot ends
  always_ff @(posedge clk) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= boundary;
  end

  // Loads are staged and only swapped in at a frame boundary to avoid tearing
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      disp_digits <= '0;
      disp_dp     <= '0;
      disp_blank  <= '0;
      upd_pend    <= 1'b0;
    end else if (load && boundary) begin
      disp_digits <= digits_i;
      disp_dp     <= dp_i;
      disp_blank  <= blank_i;
      upd_pend    <= 1'b0;
    end else if (load) begin
      pend_digits <= digits_i;
      pend_dp     <= dp_i;
      pend_blank  <= blank_i;
      upd_pend    <= 1'b1;
    end else if (boundary && upd_pend) begin
      disp_digits <= pend_digits;
      disp_dp     <= pend_dp;
      disp_blank  <= pend_blank;
      upd_pend    <= 1'b0;
    end
  end

  // Leading zeros are blanked from the top digit down; digit 0 always shows
  always_comb begin
    lz_mask = '0;
    lz_run  = lzb_en;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (lz_run && (disp_digits[4*k +: 4] == 4'd0)) lz_mask[k] = 1'b1;
      else                                           lz_run     = 1'b0;
    end
  end

  assign cur_code = disp_digits[{idx, 2'b00} +: 4];

  seg7_glyph #(
    .HEX_EN (HEX_EN)
  ) u_glyph (
    .code    (cur_code),
    .pattern (glyph_seg)
  );

  // Forced blank outranks leading-zero blanking, which outranks the glyph
  always_comb begin
    seg_nxt = glyph_seg;
    dp_nxt  = ~disp_dp[idx];
    an_nxt  = '1;
    if (disp_blank[idx] || lz_mask[idx]) begin
      seg_nxt = SEG_BLANK;
      dp_nxt  = 1'b1;
    end
    if (int'(presc) >= GUARD) an_nxt[idx] = 1'b0;
  end

  // Registered pad drivers so the digit enables never glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= seg_nxt;
      dp  <= dp_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - self-checking bench for seg7_scan_mux
module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_i = 16'h0;
  logic [3:0]  dp_i = 4'h0;
  logic [3:0]  blank_i = 4'h0;
  logic        lzb_en = 1'b0;
  logic        load = 1'b0;

  logic [6:0]  seg_h, seg_n;
  logic        dp_h, dp_n;
  logic [3:0]  an_h, an_n;
  logic        pend_h, pend_n;
  logic        ft_h, ft_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(.N_DIGITS(4), .CLK_DIV(4), .GUARD(1), .HEX_EN(1)) u_hex (
    .clk(clk), .rst(rst), .digits_i(digits_i), .dp_i(dp_i), .blank_i(blank_i),
    .lzb_en(lzb_en), .load(load), .seg(seg_h), .dp(dp_h), .an(an_h),
    .upd_pend(pend_h), .frame_tick(ft_h));

  seg7_scan_mux #(.N_DIGITS(4), .CLK_DIV(4), .GUARD(1), .HEX_EN(0)) u_dec (
    .clk(clk), .rst(rst), .digits_i(digits_i), .dp_i(dp_i), .blank_i(blank_i),
    .lzb_en(lzb_en), .load(load), .seg(seg_n), .dp(dp_n), .an(an_n),
    .upd_pend(pend_n), .frame_tick(ft_n));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] eglyph(input logic [3:0] c, input bit hex);
    case (c)
      4'd0: return 7'b0000001;  4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;  4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;  4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;  4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;  4'd9: return 7'b0000100;
      4'd10: return hex ? 7'b0001000 : 7'b1111111;
      4'd11: return hex ? 7'b1100000 : 7'b1111111;
      4'd12: return hex ? 7'b0110001 : 7'b1111111;
      4'd13: return hex ? 7'b1000010 : 7'b1111111;
      4'd14: return hex ? 7'b0110000 : 7'b1111111;
      default: return hex ? 7'b0111000 : 7'b1111111;
    endcase
  endfunction

  // Behavioural model: t counts cycles since reset; slot = t/4, digit = slot mod 4
  int          t = 0;
  bit          started = 0;
  logic [15:0] m_disp = 0, m_pdig = 0;
  logic [3:0]  m_ddp = 0, m_dbl = 0, m_pdp = 0, m_pbl = 0;
  logic        m_pend = 0;
  logic [6:0]  e_seg_h = 7'h7F, e_seg_n = 7'h7F;
  logic        e_dp = 1, e_pend = 0, e_ft = 0;
  logic [3:0]  e_an = 4'hF;

  always @(posedge clk) begin
    int pr, ix;
    bit bnd, lead;
    started = 1;
    if (rst) begin
      t = 0; m_disp = 0; m_pdig = 0; m_ddp = 0; m_dbl = 0; m_pdp = 0; m_pbl = 0;
      m_pend = 0; e_seg_h = 7'h7F; e_seg_n = 7'h7F; e_dp = 1; e_an = 4'hF;
      e_pend = 0; e_ft = 0;
    end else begin
      pr   = t % 4;
      ix   = (t / 4) % 4;
      bnd  = (t % 16) == 15;
      lead = lzb_en && (ix != 0) && ((m_disp >> (ix * 4)) == 16'd0);
      if (m_dbl[ix] || lead) begin
        e_seg_h = 7'h7F; e_seg_n = 7'h7F; e_dp = 1;
      end else begin
        e_seg_h = eglyph(m_disp[ix*4 +: 4], 1);
        e_seg_n = eglyph(m_disp[ix*4 +: 4], 0);
        e_dp    = !m_ddp[ix];
      end
      e_an = (pr >= 1) ? ~(4'b0001 << ix) : 4'hF;
      e_ft = bnd;
      if (load && bnd) begin
        m_disp = digits_i; m_ddp = dp_i; m_dbl = blank_i; m_pend = 0;
      end else if (load) begin
        m_pdig = digits_i; m_pdp = dp_i; m_pbl = blank_i; m_pend = 1;
      end else if (bnd && m_pend) begin
        m_disp = m_pdig; m_ddp = m_pdp; m_dbl = m_pbl; m_pend = 0;
      end
      e_pend = m_pend;
      t++;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      chk("seg_hex", seg_h, e_seg_h);
      chk("seg_dec", seg_n, e_seg_n);
      chk("dp_hex", dp_h, e_dp);
      chk("dp_dec", dp_n, e_dp);
      chk("an_hex", an_h, e_an);
      chk("an_dec", an_n, e_an);
      chk("pend", {pend_h, pend_n}, {e_pend, e_pend});
      chk("ftick", {ft_h, ft_n}, {e_ft, e_ft});
    end
  end

  task automatic wait_ft();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ft_h) return;
    end
    chk("wait_frame_tick_timeout", 0, 1);
  endtask

  task automatic wait_an(input logic [3:0] pat);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an_h == pat) return;
    end
    chk("wait_an_timeout", {28'h0, pat}, 32'hFFFF);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits_i = d; dp_i = p; blank_i = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int cnt_ft, n;
    int cnt_an [4];
    repeat (3) @(negedge clk);
    chk("rst_seg", seg_h, 7'b1111111);
    chk("rst_an", an_h, 4'b1111);
    chk("rst_dp_pend", {dp_h, pend_h}, 2'b10);

    // Free-running scan over one frame
    rst = 1'b0;
    cnt_ft = 0;
    for (int i = 0; i < 4; i++) cnt_an[i] = 0;
    repeat (16) begin
      @(negedge clk);
      if (ft_h) cnt_ft++;
      for (int i = 0; i < 4; i++) if (an_h == ~(4'b0001 << i)) cnt_an[i]++;
    end
    chk("frame_tick_count", cnt_ft, 1);
    chk("an_1110_count", cnt_an[0], 3);
    chk("an_1101_count", cnt_an[1], 3);
    chk("an_1011_count", cnt_an[2], 3);
    chk("an_0111_count", cnt_an[3], 3);

    // Mid-frame load with leading-zero blanking
    lzb_en = 1'b1;
    repeat (5) @(negedge clk);
    do_load(16'h0123, 4'h0, 4'h0);
    chk("pend_after_load", pend_h, 1);
    wait_ft();
    chk("pend_after_boundary", pend_h, 0);
    wait_an(4'b1110); chk("lz_d0", seg_h, 7'b0000110);
    wait_an(4'b1101); chk("lz_d1", seg_h, 7'b0010010);
    wait_an(4'b1011); chk("lz_d2", seg_h, 7'b1001111);
    wait_an(4'b0111); chk("lz_d3_blank", {seg_h, dp_h}, 8'hFF);

    // Hex glyphs versus blanked hex codes
    lzb_en = 1'b0;
    do_load(16'hABCF, 4'h0, 4'h0);
    wait_ft();
    wait_an(4'b1110); chk("hex_F", seg_h, 7'b0111000); chk("dec_F", seg_n, 7'b1111111);
    wait_an(4'b1101); chk("hex_C", seg_h, 7'b0110001); chk("dec_C", seg_n, 7'b1111111);
    wait_an(4'b1011); chk("hex_b", seg_h, 7'b1100000); chk("dec_b", seg_n, 7'b1111111);
    wait_an(4'b0111); chk("hex_A", seg_h, 7'b0001000); chk("dec_A", seg_n, 7'b1111111);

    // Load landing exactly on the boundary edge
    lzb_en = 1'b1;
    wait_ft();
    repeat (15) @(negedge clk);
    do_load(16'h0456, 4'h0, 4'h0);
    chk("bnd_ftick", ft_h, 1);
    chk("bnd_no_pend", pend_h, 0);
    wait_an(4'b1110); chk("bnd_d0", seg_h, 7'b0100000); chk("bnd_pend_later", pend_h, 0);
    wait_an(4'b1011); chk("bnd_d2", seg_h, 7'b1001100);
    wait_an(4'b0111); chk("bnd_d3_blank", seg_h, 7'b1111111);

    // Forced blank suppresses decimal point; neighbouring dp stays lit
    lzb_en = 1'b0;
    do_load(16'h8888, 4'b0110, 4'b0100);
    wait_ft();
    wait_an(4'b1101); chk("dp_d1", {seg_h, dp_h}, {7'b0000000, 1'b0});
    wait_an(4'b1011); chk("blank_d2", {seg_h, dp_h}, {7'b1111111, 1'b1});

    // Reset mid-slot discards pending data; a load during reset is ignored
    wait_an(4'b1110);
    do_load(16'h7777, 4'h0, 4'h0);
    chk("pend_before_rst", pend_h, 1);
    rst = 1'b1; digits_i = 16'h9999; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("rst_mid_off", {seg_h, dp_h, an_h}, {7'b1111111, 1'b1, 4'b1111});
    chk("rst_mid_pend", {pend_h, ft_h}, 2'b00);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (an_h == 4'b1110) break;
    end
    chk("rst_first_an_cycle", n, 2);
    chk("rst_d0_zero", seg_h, 7'b0000001);
    chk("rst_load_ignored", pend_h, 0);
    wait_ft();
    wait_an(4'b1101); chk("rst_discard_d1", seg_h, 7'b0000001);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter CLK_DIV, default 50000: clk cycles per digit slot, minimum 4.
REQ-003 Parameter GUARD, default 2: anode-off cycles at the start of each slot, 0..CLK_DIV-1.
REQ-004 Parameter HEX_EN, default 0: 1 shows codes 10..15 as hex glyphs; 0 blanks them.
REQ-005 clk  input  1  sole clock; all logic is rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 digits_i  input  4*N_DIGITS  nibble k is the code for digit k; digit 0 is least significant.
REQ-008 dp_i  input  N_DIGITS  decimal-point request per digit, 1 = lit.
REQ-009 blank_i  input  N_DIGITS  forced blank per digit, 1 = blank.
REQ-010 lzb_en  input  1  enables leading-zero blanking.
REQ-011 load  input  1  single-cycle strobe that captures digits_i, dp_i and blank_i.
REQ-012 seg  output  7  {a,b,c,d,e,f,g}, active-low (0 = segment lit).
REQ-013 dp  output  1  decimal point, active-low.
REQ-014 an  output  N_DIGITS  digit enables, active-low, at most one bit low.
REQ-015 upd_pend  output  1  high while captured data waits for a frame boundary.
REQ-016 frame_tick  output  1  one-cycle pulse when digit N_DIGITS-1 finishes its slot.

Function
REQ-017 The prescaler counts 0..CLK_DIV-1 and wraps; its terminal count is the slot tick.
REQ-018 On a slot tick, idx advances to (idx+1) mod N_DIGITS.
REQ-019 A slot tick while idx = N_DIGITS-1 is a frame boundary; frame_tick pulses on the following cycle.
REQ-020 The load strobe writes the inputs into pending registers and sets upd_pend on the next cycle.
REQ-021 A later load before the boundary overwrites pending; only the last load is shown.
REQ-022 At a frame boundary with upd_pend=1, pending data moves to the display registers and upd_pend clears.
REQ-023 If load coincides with a frame boundary, the live inputs go straight to the display registers and upd_pend stays 0.
REQ-024 Decode, active-low abcdefg: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
REQ-025 Decode continued: 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-026 With HEX_EN=1, codes 10..15 decode to A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-027 With HEX_EN=0, codes 10..15 decode to blank (1111111).
REQ-028 With lzb_en=1, zero digits from index N_DIGITS-1 downward are blanked until the first nonzero digit; digit 0 is never blanked by this rule.
REQ-029 A blanked digit drives seg=1111111 and dp=1 regardless of its dp_i bit.
REQ-030 Blanking priority: blank_i, then leading-zero blanking, then decode.
REQ-031 an[idx]=0 only when prescaler >= GUARD; all other an bits are 1.
REQ-032 seg, dp and an are registered and reflect the idx and prescaler values of the previous cycle, giving one cycle of latency.
REQ-033 lzb_en is sampled live and takes effect on the next output register update.

Reset
REQ-034 While rst=1: idx=0, prescaler=0, and display and pending registers are 0.
REQ-035 While rst=1: upd_pend=0, frame_tick=0, seg=1111111, dp=1 and an all 1.
REQ-036 A load in the same cycle as rst is ignored.
REQ-037 Reset mid-frame discards pending data.
REQ-038 After rst deasserts, scanning restarts at digit 0 with a full slot.

Structure
REQ-039 Package seg7_pkg holds the sixteen glyph constants and the SEG_BLANK constant.
REQ-040 One combinational sub-module, seg7_glyph, maps a 4-bit code and HEX_EN to the 7-bit pattern.
REQ-041 The top level holds the prescaler, scan counter, shadow registers, leading-zero blanking and output registers.

Verification (N_DIGITS=4, CLK_DIV=4, GUARD=1)
REQ-042 Stimulus: release rst and run 16 cycles. Required: an steps 1110, 1101, 1011, 0111; each low for 3 of every 4 cycles; frame_tick pulses once.
REQ-043 Stimulus: load digits 0x0123 mid-frame with lzb_en=1. Required: upd_pend=1 until the boundary; then digit 3 is blank and digits 2..0 show 1, 2, 3 as 1001111, 0010010, 0000110.
REQ-044 Stimulus: HEX_EN=1, load 0xABCF. Required: A, b, C, F patterns appear.
REQ-045 Stimulus: same load 0xABCF with HEX_EN=0. Required: all four digits show 1111111.
REQ-046 Stimulus: load asserted on the exact boundary cycle. Required: new data appears in the next slot and upd_pend never rises.
REQ-047 Stimulus: dp_i=0100 and blank_i=0100. Required: digit 2 shows seg=1111111 and dp=1.
REQ-048 Stimulus: assert rst mid-slot with data pending. Required: outputs are off the next cycle, upd_pend=0, and digit 0 is enabled at cycle GUARD+1 after release.
